// File: rtl/motor_pkg.sv
// motor_pkg
// Shared types, default widths and the duty saturation helper for the
// differential drive PWM block.
//   chan_state_t : per-channel state (IDLE, RUN, BRAKE)
//   clamp_duty   : clamps a signed value to [-(2**duty_w-1), +(2**duty_w-1)]
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BRAKE
  } chan_state_t;

  localparam int DEF_CONTROL_WIDTH    = 16;
  localparam int DEF_DUTY_WIDTH       = 10;
  localparam int DEF_DEADTIME_PERIODS = 2;

  // Operates on a 32-bit container so one helper serves any duty width;
  // callers narrow the result to DUTY_WIDTH+1 bits.
  function automatic logic signed [31:0] clamp_duty(input logic signed [31:0] value,
                                                    input int               duty_w);
    logic signed [31:0] max_duty;
    max_duty = (32'sd1 <<< duty_w) - 32'sd1;
    if (value > max_duty) begin
      return max_duty;
    end else if (value < -max_duty) begin
      return -max_duty;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One motor side: holds state, magnitude, direction and brake counter and
// drives the registered PWM compare.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : low forces IDLE on the next clock
//   boundary     : PWM period boundary tick (already qualified by clk_en/en)
//   cnt_next     : value the shared counter takes on this clock edge
//   target       : clamped signed target duty for this side
//   pwm, dir     : registered H-bridge drive, dir 1 = forward
//   duty         : registered signed applied duty
module pwm_channel
  import motor_pkg::*;
#(
  parameter int DUTY_WIDTH       = DEF_DUTY_WIDTH,
  parameter int DEADTIME_PERIODS = DEF_DEADTIME_PERIODS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         boundary,
  input  logic        [DUTY_WIDTH-1:0] cnt_next,
  input  logic signed [DUTY_WIDTH:0]   target,
  output logic                         pwm,
  output logic                         dir,
  output logic signed [DUTY_WIDTH:0]   duty
);

  localparam int BRAKE_W = (DEADTIME_PERIODS < 2) ? 1 : $clog2(DEADTIME_PERIODS + 1);
  localparam logic [BRAKE_W-1:0] BRAKE_LOAD = BRAKE_W'(DEADTIME_PERIODS);

  chan_state_t               state, state_n;
  logic [DUTY_WIDTH-1:0]     mag, mag_n, new_mag;
  logic                      dir_n, new_fwd, pwm_n;
  logic [BRAKE_W-1:0]        brake_cnt, brake_n;
  logic signed [DUTY_WIDTH:0] duty_n, mag_s;

  always_comb begin
    new_fwd = ~target[DUTY_WIDTH];
    // |target| never exceeds MAX_DUTY, so it fits in DUTY_WIDTH bits.
    new_mag = DUTY_WIDTH'(target[DUTY_WIDTH] ? -target : target);

    state_n = state;
    mag_n   = mag;
    dir_n   = dir;
    brake_n = brake_cnt;

    if (!en) begin
      state_n = IDLE;
      mag_n   = '0;
      dir_n   = 1'b1;
      brake_n = '0;
    end else if (boundary) begin
      unique case (state)
        IDLE: begin
          state_n = RUN;
          mag_n   = new_mag;
          dir_n   = new_fwd;
        end
        RUN: begin
          // A nonzero request in the opposite direction must pass through
          // the dead periods first; a zero request keeps the old direction.
          if ((new_fwd != dir) && (new_mag != '0)) begin
            state_n = BRAKE;
            brake_n = BRAKE_LOAD;
            mag_n   = '0;
          end else begin
            mag_n = new_mag;
          end
        end
        BRAKE: begin
          if (brake_cnt > BRAKE_W'(1)) begin
            brake_n = brake_cnt - BRAKE_W'(1);
          end else begin
            state_n = RUN;
            brake_n = '0;
            mag_n   = new_mag;
            if (new_mag != '0) begin
              dir_n = new_fwd;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Compare against the counter's next value so the registered pwm always
    // matches the registered counter and magnitude.
    pwm_n  = (state_n == RUN) && (cnt_next < mag_n);
    mag_s  = signed'({1'b0, mag_n});
    duty_n = (state_n == RUN) ? (dir_n ? mag_s : -mag_s) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mag       <= '0;
      dir       <= 1'b1;
      brake_cnt <= '0;
      pwm       <= 1'b0;
      duty      <= '0;
    end else begin
      state     <= state_n;
      mag       <= mag_n;
      dir       <= dir_n;
      brake_cnt <= brake_n;
      pwm       <= pwm_n;
      duty      <= duty_n;
    end
  end

endmodule

// File: rtl/differential_drive_pwm.sv
// differential_drive_pwm
// Mixes a signed steering correction with a base speed into left/right
// saturated PWM drive with direction and reversal braking.
//   clk, reset_n       : clock, asynchronous active-low reset
//   clk_en             : PWM tick strobe, all counting advances only on ticks
//   en                 : enable, low forces idle on the next clock
//   base_speed         : unsigned forward speed common to both sides
//   control_in         : signed correction, positive makes the left side faster
//   pwm_l/r, dir_l/r   : registered H-bridge drive, dir 1 = forward
//   duty_l/r           : registered signed applied duty
//   period_start       : one-clock pulse after every period boundary tick
module differential_drive_pwm
  import motor_pkg::*;
#(
  parameter int CONTROL_WIDTH    = DEF_CONTROL_WIDTH,
  parameter int DUTY_WIDTH       = DEF_DUTY_WIDTH,
  parameter int DEADTIME_PERIODS = DEF_DEADTIME_PERIODS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clk_en,
  input  logic                            en,
  input  logic        [DUTY_WIDTH-1:0]    base_speed,
  input  logic signed [CONTROL_WIDTH-1:0] control_in,
  output logic                            pwm_l,
  output logic                            pwm_r,
  output logic                            dir_l,
  output logic                            dir_r,
  output logic signed [DUTY_WIDTH:0]      duty_l,
  output logic signed [DUTY_WIDTH:0]      duty_r,
  output logic                            period_start
);

  localparam int SUM_W = ((CONTROL_WIDTH > DUTY_WIDTH + 1) ? CONTROL_WIDTH : DUTY_WIDTH + 1) + 1;
  localparam logic [DUTY_WIDTH-1:0] MAX_DUTY = '1;

  logic [DUTY_WIDTH-1:0]      cnt, cnt_n;
  logic                       active, tick, boundary;
  logic signed [SUM_W-1:0]    base_ext, ctrl_ext, sum_l, sum_r;
  logic signed [DUTY_WIDTH:0] target_l, target_r;

  // Mixing is wide enough that neither sum can overflow before clamping.
  assign base_ext = SUM_W'(base_speed);
  assign ctrl_ext = SUM_W'(control_in);
  assign sum_l    = base_ext + ctrl_ext;
  assign sum_r    = base_ext - ctrl_ext;
  assign target_l = (DUTY_WIDTH + 1)'(clamp_duty(32'(sum_l), DUTY_WIDTH));
  assign target_r = (DUTY_WIDTH + 1)'(clamp_duty(32'(sum_r), DUTY_WIDTH));

  // The first tick after enable is a boundary too; it leaves cnt at 0 so
  // the first period after enabling is a full 2**DUTY_WIDTH ticks.
  assign tick     = clk_en & en;
  assign boundary = tick & (~active | (cnt == MAX_DUTY));

  always_comb begin
    cnt_n = cnt;
    if (!en) begin
      cnt_n = '0;
    end else if (tick) begin
      cnt_n = active ? cnt + DUTY_WIDTH'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      active       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      period_start <= boundary;
      if (!en) begin
        active <= 1'b0;
      end else if (tick) begin
        active <= 1'b1;
      end
    end
  end

  pwm_channel #(
    .DUTY_WIDTH      (DUTY_WIDTH),
    .DEADTIME_PERIODS(DEADTIME_PERIODS)
  ) u_left (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .boundary(boundary),
    .cnt_next(cnt_n),
    .target  (target_l),
    .pwm     (pwm_l),
    .dir     (dir_l),
    .duty    (duty_l)
  );

  pwm_channel #(
    .DUTY_WIDTH      (DUTY_WIDTH),
    .DEADTIME_PERIODS(DEADTIME_PERIODS)
  ) u_right (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .boundary(boundary),
    .cnt_next(cnt_n),
    .target  (target_r),
    .pwm     (pwm_r),
    .dir     (dir_r),
    .duty    (duty_r)
  );

endmodule

// File: tb/tb_differential_drive_pwm.sv
// Testbench for differential_drive_pwm (DUTY_WIDTH=4, DEADTIME_PERIODS=2).
// Vector table plus directed corner sequences, with a per-cycle reference
// model checked on every falling edge during directed and random stimulus.
module tb_differential_drive_pwm;

  localparam int CW   = 16;
  localparam int DW   = 4;
  localparam int DT   = 2;
  localparam int MAXD = 15;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clk_en = 1'b1;
  logic                 en = 1'b0;
  logic        [DW-1:0] base_speed = '0;
  logic signed [CW-1:0] control_in = '0;
  logic                 pwm_l, pwm_r, dir_l, dir_r, period_start;
  logic signed [DW:0]   duty_l, duty_r;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  differential_drive_pwm #(
    .CONTROL_WIDTH   (CW),
    .DUTY_WIDTH      (DW),
    .DEADTIME_PERIODS(DT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .en          (en),
    .base_speed  (base_speed),
    .control_in  (control_in),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .dir_l       (dir_l),
    .dir_r       (dir_r),
    .duty_l      (duty_l),
    .duty_r      (duty_r),
    .period_start(period_start)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Side state: 0 idle, 1 running, 2 braking.
  int m_cnt = 0;
  bit m_started = 1'b0;
  bit m_ps = 1'b0;
  int m_st[2]  = '{0, 0};
  int m_mag[2] = '{0, 0};
  bit m_dir[2] = '{1'b1, 1'b1};
  int m_brk[2] = '{0, 0};

  function automatic int clampi(input int v);
    if (v > MAXD) return MAXD;
    if (v < -MAXD) return -MAXD;
    return v;
  endfunction

  task automatic m_idle();
    m_cnt = 0;
    m_started = 1'b0;
    m_ps = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_st[s] = 0; m_mag[s] = 0; m_dir[s] = 1'b1; m_brk[s] = 0;
    end
  endtask

  task automatic m_side(input int s, input int t);
    int mg;
    bit fwd;
    mg  = (t < 0) ? -t : t;
    fwd = (t >= 0);
    case (m_st[s])
      0: begin m_st[s] = 1; m_mag[s] = mg; m_dir[s] = fwd; end
      1: begin
        if (mg != 0 && fwd != m_dir[s]) begin
          m_st[s] = 2; m_brk[s] = DT; m_mag[s] = 0;
        end else begin
          m_mag[s] = mg;
        end
      end
      default: begin
        if (m_brk[s] > 1) begin
          m_brk[s] = m_brk[s] - 1;
        end else begin
          m_st[s] = 1; m_brk[s] = 0; m_mag[s] = mg;
          if (mg != 0) m_dir[s] = fwd;
        end
      end
    endcase
  endtask

  initial begin
    bit bnd;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || !en) begin
        m_idle();
      end else if (clk_en) begin
        bnd = !m_started || (m_cnt == MAXD);
        m_cnt = m_started ? (m_cnt + 1) % (MAXD + 1) : 0;
        m_started = 1'b1;
        if (bnd) begin
          m_side(0, clampi(int'(base_speed) + int'(control_in)));
          m_side(1, clampi(int'(base_speed) - int'(control_in)));
        end
        m_ps = bnd;
      end else begin
        m_ps = 1'b0;
      end
    end
  end

  function automatic int exp_pwm(input int s);
    return (m_st[s] == 1 && m_cnt < m_mag[s]) ? 1 : 0;
  endfunction

  function automatic int exp_duty(input int s);
    if (m_st[s] != 1) return 0;
    return m_dir[s] ? m_mag[s] : -m_mag[s];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        chk("model_pwm_l", pwm_l, exp_pwm(0));
        chk("model_pwm_r", pwm_r, exp_pwm(1));
        chk("model_dir_l", dir_l, m_dir[0]);
        chk("model_dir_r", dir_r, m_dir[1]);
        chk("model_duty_l", duty_l, exp_duty(0));
        chk("model_duty_r", duty_r, exp_duty(1));
        chk("model_period_start", period_start, m_ps);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns just after the first boundary of a fresh run (counter at 0).
  task automatic start_run(input int b, input int c);
    en = 1'b0;
    tick();
    base_speed = DW'(b);
    control_in = CW'(c);
    en = 1'b1;
    tick();
  endtask

  typedef struct {
    int base; int ctrl;
    int dl; int dr; int dirl; int dirr; int hl; int hr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc, acc2, gap;

    vecs[0] = '{8, 0, 8, 8, 1, 1, 8, 8};
    vecs[1] = '{8, 20, 15, -12, 1, 0, 15, 12};
    vecs[2] = '{0, -5, -5, 5, 0, 1, 5, 5};
    vecs[3] = '{15, 0, 15, 15, 1, 1, 15, 15};
    vecs[4] = '{0, 0, 0, 0, 1, 1, 0, 0};
    vecs[5] = '{3, -32768, -15, 15, 0, 1, 15, 15};
    vecs[6] = '{15, 32767, 15, -15, 1, 0, 15, 15};
    vecs[7] = '{5, -3, 2, 8, 1, 1, 2, 8};

    // Reset state
    reset_n = 1'b0;
    en = 1'b0;
    clk_en = 1'b1;
    ticks(2);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_pwm_r", pwm_r, 0);
    chk("rst_dir_l", dir_l, 1);
    chk("rst_dir_r", dir_r, 1);
    chk("rst_duty_l", duty_l, 0);
    chk("rst_duty_r", duty_r, 0);
    chk("rst_period_start", period_start, 0);
    reset_n = 1'b1;
    check_on = 1'b1;

    // en held low for 40 clocks
    base_speed = 4'd8;
    acc = 0; acc2 = 0; gap = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      acc  += period_start;
      acc2 += pwm_l + pwm_r;
      gap  += (!dir_l) + (!dir_r);
    end
    chk("idle_period_start_pulses", acc, 0);
    chk("idle_pwm_highs", acc2, 0);
    chk("idle_dir_not_fwd", gap, 0);

    // period_start spacing
    start_run(8, 0);
    chk("ps_first_boundary", period_start, 1);
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (period_start) begin
        gap = i;
        break;
      end
    end
    chk("ps_gap", gap, 16);

    // Vector table: duty/dir after the first boundary and highs per period
    foreach (vecs[k]) begin
      start_run(vecs[k].base, vecs[k].ctrl);
      chk($sformatf("vec%0d_duty_l", k), duty_l, vecs[k].dl);
      chk($sformatf("vec%0d_duty_r", k), duty_r, vecs[k].dr);
      chk($sformatf("vec%0d_dir_l", k), dir_l, vecs[k].dirl);
      chk($sformatf("vec%0d_dir_r", k), dir_r, vecs[k].dirr);
      acc = 0; acc2 = 0;
      for (int i = 0; i < 16; i++) begin
        acc  += pwm_l;
        acc2 += pwm_r;
        tick();
      end
      chk($sformatf("vec%0d_highs_l", k), acc, vecs[k].hl);
      chk($sformatf("vec%0d_highs_r", k), acc2, vecs[k].hr);
    end

    // Reversal while running: right side brakes for two full periods
    start_run(8, 0);
    ticks(5);
    control_in = 16'sd12;
    ticks(11);
    chk("rev_duty_l", duty_l, 15);
    chk("rev_brake_duty_r", duty_r, 0);
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      acc += pwm_r + (!dir_r);
      tick();
    end
    chk("rev_brake_violations", acc, 0);
    chk("rev_dir_r", dir_r, 0);
    chk("rev_duty_r", duty_r, -4);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      acc += pwm_r;
      tick();
    end
    chk("rev_highs_r", acc, 4);

    // Mid-period control change is ignored until the next boundary
    start_run(8, 0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      acc += pwm_l;
      tick();
    end
    control_in = 16'sd4;
    for (int i = 0; i < 11; i++) begin
      acc += pwm_l;
      if (i == 10) chk("mid_duty_l_before_boundary", duty_l, 8);
      tick();
    end
    chk("mid_highs_l", acc, 8);
    chk("mid_duty_l_after", duty_l, 12);
    chk("mid_duty_r_after", duty_r, 4);

    // en dropped mid-period
    start_run(8, 0);
    ticks(7);
    chk("enlow_pwm_before", pwm_l, 1);
    en = 1'b0;
    tick();
    chk("enlow_pwm_l", pwm_l, 0);
    chk("enlow_duty_l", duty_l, 0);
    chk("enlow_period_start", period_start, 0);
    en = 1'b1;
    tick();
    chk("enrise_period_start", period_start, 1);

    // Reset pulse during BRAKE, then a direct load without braking
    start_run(8, 0);
    ticks(5);
    control_in = 16'sd12;
    ticks(11);
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk("brk_rst_pwm_l", pwm_l, 0);
    chk("brk_rst_duty_l", duty_l, 0);
    chk("brk_rst_dir_r", dir_r, 1);
    chk("brk_rst_duty_r", duty_r, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_dir_r", dir_r, 0);
    chk("post_rst_duty_r", duty_r, -4);
    chk("post_rst_duty_l", duty_l, 15);

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 30) == 0) base_speed = DW'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        if ($urandom_range(0, 3) == 0) control_in = CW'($urandom);
        else control_in = CW'(int'($urandom_range(0, 60)) - 30);
      end
      if (en && $urandom_range(0, 200) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 10) == 0) en = 1'b1;
      if ($urandom_range(0, 700) == 0) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      tick();
    end

    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/differential_drive_pwm.md
# differential_drive_pwm

- Converts the signed steering correction from the PID stage into left/right motor PWM and direction outputs for the wall follower.
- Mixes the correction against a base speed and saturates each side.
- Updates duty only at PWM period boundaries and inserts a braking dead period on every direction reversal.
- Sits between the PID controller output and the H-bridge pins.

## Interface
- CONTROL_WIDTH, 16, width of signed `control_in`
- DUTY_WIDTH, 10, PWM resolution; period = 2**DUTY_WIDTH `clk_en` ticks; MAX_DUTY = 2**DUTY_WIDTH-1
- DEADTIME_PERIODS, 2, full PWM periods of forced-off output on a direction reversal (≥1)
- clk  input  1  system clock; one clock
- reset_n  input  1  asynchronous, active-low reset
- clk_en  input  1  PWM tick strobe; all counting advances only on ticks
- en  input  1  enable; low forces the idle state
- base_speed  input  DUTY_WIDTH  unsigned forward speed common to both sides
- control_in  input  CONTROL_WIDTH  signed correction, positive steers right (left faster)
- pwm_l, pwm_r  output  1  registered PWM drive
- dir_l, dir_r  output  1  registered direction, 1 = forward
- duty_l, duty_r  output  DUTY_WIDTH+1  signed applied duty (debug)
- period_start  output  1  one-clk pulse on each boundary tick

## Operation
- Mixing, SUM_W = max(CONTROL_WIDTH, DUTY_WIDTH+1)+1 signed bits, no overflow:
  - target_l = base_speed + control_in
  - target_r = base_speed - control_in
  - Each target is clamped to [-MAX_DUTY, +MAX_DUTY].
  - mag = |clamped|; sign negative → reverse.
- Shared counter cnt (0..MAX_DUTY):
  - Increments on `clk_en` while en=1 and wraps to 0.
  - Held at 0 while idle.
- Boundary tick:
  - A `clk_en` tick with cnt==MAX_DUTY, or the first `clk_en` tick after en rises.
  - `control_in` and `base_speed` are sampled only on boundary ticks; mid-period changes are ignored.
- Per-channel state:
  - IDLE:
    - Outputs: pwm=0, dir=1, duty=0.
    - At a boundary, load the target and go to RUN. The direction is set directly, with no brake.
  - RUN, at each boundary:
    - If the new sign differs from dir and the new mag≠0: go to BRAKE, set brake_cnt=DEADTIME_PERIODS, pwm=0, duty=0, dir unchanged.
    - Otherwise load the new mag. When mag=0, dir is kept.
  - BRAKE, at each boundary:
    - If brake_cnt>1, decrement.
    - Otherwise take a fresh sample and go to RUN, with direction change allowed.
    - If the sign has returned to the old dir, simply resume.
- PWM: pwm = RUN && (cnt < mag).
  - mag=MAX_DUTY is high for MAX_DUTY of 2**DUTY_WIDTH ticks.
  - mag=0 is always low.
- en=0 takes priority over clk_en. On the next clk edge, regardless of clk_en:
  - Both channels go to IDLE.
  - cnt=0 and brake counters clear.

## Timing
- Reset values (asynchronous, immediate on reset_n low): pwm 0, dir 1, duty 0, period_start 0, cnt 0, state IDLE.
- All outputs are registered.
  - A value loaded on a boundary tick appears one clk after that tick.
  - pwm follows cnt with the same one-clk registration, so pwm equals (cnt_reg < mag_reg) && RUN at all times.
- Sample-to-output latency is at most one PWM period plus one clk.
  - A reversal adds DEADTIME_PERIODS periods.
- Between `clk_en` ticks every register holds.
- A reset_n assertion mid-BRAKE or mid-period aborts immediately. After release, the block behaves as fresh from IDLE.

## Structure
- Package `motor_pkg`:
  - chan_state_t enum {IDLE, RUN, BRAKE}
  - Saturation helper function clamp_duty
  - Default width constants
- Sub-module `pwm_channel`: one side.
  - Owns state, mag, dir, brake counter and the pwm compare.
  - Inputs: boundary strobe, shared cnt, signed target.
- Top level:
  - Owns the shared counter, the boundary/period_start logic and the mixing.
  - Instantiates two `pwm_channel`.

## Test plan
All scenarios use DUTY_WIDTH=4, DEADTIME_PERIODS=2, clk_en every cycle.
- Reset with en=0: all outputs at reset values. en held low for 40 clk → pwm stays 0, dir 1, period_start never pulses.
- base=8, control=0, en=1 → each period both pwm high exactly 8 of 16 ticks; dir 1; duty 8; period_start every 16 clk.
- From IDLE, base=8, control=+20 → left clamps to duty 15 (high 15/16); right target -12 gives dir_r=0 and duty -12 on the first period, with no brake.
- Running base=8, control=0, then control=+12 → left duty 15 after the next boundary. Right pwm=0 for 2 full periods with dir_r=1, then dir_r=0 and high 4/16.
- control changed mid-period (cnt=5) → pwm pattern is unchanged until the next boundary; the new duty is visible one clk after the boundary tick.
- en low at cnt=7 → pwm 0 and cnt 0 on the next clk. reset_n pulsed during BRAKE → immediate reset values; the next enable loads directly with no brake.
